rename_rat_freelist: RTL and testbench

// Parametrised register-rename stage between decode and dispatch. Holds a speculative RAT, an architectural RAT and a circular free list.

---
 rtl/rename_rat_freelist_if.sv | 48 ++++
 rtl/rename_rat_freelist.sv | 188 ++++++++++++++++++
 tb/tb_rename_rat_freelist.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rename_rat_freelist_if.sv
// Decode/dispatch/commit bundle for the rename stage; the slave side is the rename block.
// `RENAME_STALL_CNT_EN adds the o_stall_cnt observation port.
interface rename_rat_freelist_if #(
    parameter int RENAME_W = 4,
    parameter int COMMIT_W = 4,
    parameter int PRW      = 6
);
    logic                         i_squash_vld;
    logic [RENAME_W-1:0]          i_dec_vld;
    logic                         o_dec_rdy;
    logic [RENAME_W*5-1:0]        i_rs1;
    logic [RENAME_W*5-1:0]        i_rs2;
    logic [RENAME_W*5-1:0]        i_rd;
    logic [RENAME_W-1:0]          i_rd_wen;
    logic [RENAME_W-1:0]          o_ren_vld;
    logic                         i_disp_rdy;
    logic [RENAME_W*PRW-1:0]      o_prs1;
    logic [RENAME_W*PRW-1:0]      o_prs2;
    logic [RENAME_W*PRW-1:0]      o_prd;
    logic [RENAME_W*PRW-1:0]      o_old_prd;
    logic [COMMIT_W-1:0]          i_cmt_vld;
    logic [COMMIT_W-1:0]          i_cmt_wen;
    logic [COMMIT_W*5-1:0]        i_cmt_ard;
    logic [COMMIT_W*PRW-1:0]      i_cmt_prd;
    logic [COMMIT_W*PRW-1:0]      i_cmt_old_prd;
    logic [PRW:0]                 o_free_cnt;
`ifdef RENAME_STALL_CNT_EN
    logic [31:0]                  o_stall_cnt;
`endif

    modport master (
`ifdef RENAME_STALL_CNT_EN
        input  o_stall_cnt,
`endif
        output i_squash_vld, i_dec_vld, i_rs1, i_rs2, i_rd, i_rd_wen, i_disp_rdy,
        output i_cmt_vld, i_cmt_wen, i_cmt_ard, i_cmt_prd, i_cmt_old_prd,
        input  o_dec_rdy, o_ren_vld, o_prs1, o_prs2, o_prd, o_old_prd, o_free_cnt
    );

    modport slave (
`ifdef RENAME_STALL_CNT_EN
        output o_stall_cnt,
`endif
        input  i_squash_vld, i_dec_vld, i_rs1, i_rs2, i_rd, i_rd_wen, i_disp_rdy,
        input  i_cmt_vld, i_cmt_wen, i_cmt_ard, i_cmt_prd, i_cmt_old_prd,
        output o_dec_rdy, o_ren_vld, o_prs1, o_prs2, o_prd, o_old_prd, o_free_cnt
    );
endinterface

// File: rtl/rename_rat_freelist.sv
// Register rename: speculative + architectural RAT, circular free list, one registered output stage.
// `RENAME_STALL_CNT_EN adds a saturating 32-bit decode-stall cycle counter on o_stall_cnt.
module rename_rat_freelist #(
    parameter int RENAME_W  = 4,
    parameter int COMMIT_W  = 4,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    rename_rat_freelist_if.slave ifc
);
    localparam int PRW  = $clog2(PHYS_REGS);
    localparam int FL_D = PHYS_REGS - ARCH_REGS;
    localparam int FLW  = $clog2(FL_D);
    localparam int PTW  = FLW + 1;

    logic [RENAME_W-1:0][4:0]     rs1, rs2, rd;
    logic [COMMIT_W-1:0][4:0]     cmt_ard;
    logic [COMMIT_W-1:0][PRW-1:0] cmt_prd, cmt_old_prd;

    assign rs1         = ifc.i_rs1;
    assign rs2         = ifc.i_rs2;
    assign rd          = ifc.i_rd;
    assign cmt_ard     = ifc.i_cmt_ard;
    assign cmt_prd     = ifc.i_cmt_prd;
    assign cmt_old_prd = ifc.i_cmt_old_prd;

    logic [PRW-1:0] spec_rat    [ARCH_REGS];
    logic [PRW-1:0] arch_rat    [ARCH_REGS];
    logic [PRW-1:0] arch_rat_nx [ARCH_REGS];
    logic [PRW-1:0] fl          [FL_D];

    logic [PTW-1:0] head, arch_head, tail, free_cnt;
    logic [PTW-1:0] head_nx, n_alloc, n_cmt;

    logic [RENAME_W-1:0]           alloc;
    logic [COMMIT_W-1:0]           cmt_push;
    logic [COMMIT_W-1:0][FLW-1:0]  push_idx;
    logic [RENAME_W-1:0][PRW-1:0]  prs1_p0, prs2_p0, prd_p0, old_prd_p0;
    logic [RENAME_W-1:0][PRW-1:0]  prs1_p1, prs2_p1, prd_p1, old_prd_p1;
    logic [RENAME_W-1:0]           vld_p1;
    logic                          dec_rdy, accept;

    // Readiness uses the worst-case group size so it never depends on rd/wen decode.
    assign dec_rdy = !ifc.i_squash_vld && (free_cnt >= PTW'(RENAME_W)) &&
                     (!(|vld_p1) || ifc.i_disp_rdy);
    assign accept  = dec_rdy && (|ifc.i_dec_vld);

    // ---- stage p0: allocate from the free-list head in lane order ----
    always_comb begin
        n_alloc = '0;
        alloc   = '0;
        prd_p0  = '0;
        for (int j = 0; j < RENAME_W; j++) begin
            alloc[j] = ifc.i_dec_vld[j] && ifc.i_rd_wen[j] && (rd[j] != '0);
            if (alloc[j]) begin
                prd_p0[j] = fl[FLW'(head + n_alloc)];
                n_alloc   = n_alloc + PTW'(1);
            end
        end
    end

    // x0 always reads p0 because spec_rat[0] is never written and no alloc lane has rd==0.
    always_comb begin
        prs1_p0    = '0;
        prs2_p0    = '0;
        old_prd_p0 = '0;
        for (int j = 0; j < RENAME_W; j++) begin
            prs1_p0[j]    = spec_rat[rs1[j]];
            prs2_p0[j]    = spec_rat[rs2[j]];
            old_prd_p0[j] = alloc[j] ? spec_rat[rd[j]] : '0;
            for (int i = 0; i < RENAME_W; i++) begin
                if (i < j && alloc[i]) begin
                    if (rd[i] == rs1[j]) prs1_p0[j] = prd_p0[i];
                    if (rd[i] == rs2[j]) prs2_p0[j] = prd_p0[i];
                    if (alloc[j] && rd[i] == rd[j]) old_prd_p0[j] = prd_p0[i];
                end
            end
        end
    end

    always_comb begin
        n_cmt    = '0;
        cmt_push = '0;
        push_idx = '0;
        for (int r = 0; r < ARCH_REGS; r++) arch_rat_nx[r] = arch_rat[r];
        for (int k = 0; k < COMMIT_W; k++) begin
            push_idx[k] = FLW'(tail + n_cmt);
            if (ifc.i_cmt_vld[k] && ifc.i_cmt_wen[k]) begin
                cmt_push[k] = 1'b1;
                if (cmt_ard[k] != '0) arch_rat_nx[cmt_ard[k]] = cmt_prd[k];
                n_cmt = n_cmt + PTW'(1);
            end
        end
    end

    // Squash rewinds head to the committed head, which tracks tail exactly FL_D behind.
    always_comb begin
        head_nx = head;
        if (ifc.i_squash_vld)  head_nx = arch_head + n_cmt;
        else if (accept)       head_nx = head + n_alloc;
    end

    // Tail starts one full lap ahead of head: same slot index, opposite wrap bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            arch_head <= '0;
            tail      <= PTW'(FL_D);
            free_cnt  <= PTW'(FL_D);
        end else begin
            head      <= head_nx;
            arch_head <= arch_head + n_cmt;
            tail      <= tail + n_cmt;
            free_cnt  <= tail + n_cmt - head_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                spec_rat[r] <= PRW'(r);
                arch_rat[r] <= PRW'(r);
            end
            for (int i = 0; i < FL_D; i++) fl[i] <= PRW'(ARCH_REGS + i);
        end else begin
            for (int r = 0; r < ARCH_REGS; r++) arch_rat[r] <= arch_rat_nx[r];
            if (ifc.i_squash_vld) begin
                for (int r = 0; r < ARCH_REGS; r++) spec_rat[r] <= arch_rat_nx[r];
            end else if (accept) begin
                for (int j = 0; j < RENAME_W; j++)
                    if (alloc[j]) spec_rat[rd[j]] <= prd_p0[j];
            end
            for (int k = 0; k < COMMIT_W; k++)
                if (cmt_push[k]) fl[push_idx[k]] <= cmt_old_prd[k];
        end
    end

    // ---- stage p1: registered rename results, held until dispatch accepts ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1     <= '0;
            prs1_p1    <= '0;
            prs2_p1    <= '0;
            prd_p1     <= '0;
            old_prd_p1 <= '0;
        end else if (ifc.i_squash_vld) begin
            vld_p1     <= '0;
        end else if (accept) begin
            vld_p1     <= ifc.i_dec_vld;
            prs1_p1    <= prs1_p0;
            prs2_p1    <= prs2_p0;
            prd_p1     <= prd_p0;
            old_prd_p1 <= old_prd_p0;
        end else if (ifc.i_disp_rdy) begin
            vld_p1     <= '0;
        end
    end

    assign ifc.o_dec_rdy  = dec_rdy;
    assign ifc.o_ren_vld  = vld_p1;
    assign ifc.o_prs1     = prs1_p1;
    assign ifc.o_prs2     = prs2_p1;
    assign ifc.o_prd      = prd_p1;
    assign ifc.o_old_prd  = old_prd_p1;
    assign ifc.o_free_cnt = (PRW+1)'(free_cnt);

`ifdef RENAME_STALL_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic [31:0] stall_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if ((|ifc.i_dec_vld) && !dec_rdy && !ifc.i_squash_vld)
            stall_cnt <= sat_inc32(stall_cnt);
    end
    assign ifc.o_stall_cnt = stall_cnt;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !((n_cmt != '0) && (free_cnt == PTW'(FL_D))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(accept && (n_alloc > free_cnt)));
endmodule

// File: tb/tb_rename_rat_freelist.sv
// Bench for rename_rat_freelist: directed scenarios plus random traffic against a
// sequential rename model built from queues (free list, in-flight list) and RAT arrays.
module tb_rename_rat_freelist;
    localparam int RW = 4;
    localparam int CW = 4;
    localparam int PRW = 6;

    logic clk;
    logic rst;

    rename_rat_freelist_if #(.RENAME_W(RW), .COMMIT_W(CW), .PRW(PRW)) bus ();

    rename_rat_freelist #(.RENAME_W(RW), .COMMIT_W(CW), .ARCH_REGS(32), .PHYS_REGS(64)) dut (
        .clk (clk),
        .rst (rst),
        .ifc (bus)
    );

    typedef struct { logic [4:0] ard; logic [5:0] prd; logic [5:0] old; } rec_t;

    logic [5:0] spec_m [32];
    logic [5:0] arch_m [32];
    logic [5:0] fl_q [$];
    rec_t       infl [$];
    logic       exp_vld [RW];
    logic [5:0] e_prs1 [RW];
    logic [5:0] e_prs2 [RW];
    logic [5:0] e_prd  [RW];
    logic [5:0] e_old  [RW];
    longint     stall_m;
    int         n_chk = 0;
    int         n_bad = 0;

    logic [RW-1:0] d_vld, d_wen;
    logic [4:0]    d_rs1 [RW];
    logic [4:0]    d_rs2 [RW];
    logic [4:0]    d_rd  [RW];
    logic [CW-1:0] c_vld, c_wen;
    logic [4:0]    c_ard [CW];
    logic [5:0]    c_prd [CW];
    logic [5:0]    c_old [CW];
    logic          sq, disp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] lane6(input logic [RW*PRW-1:0] v, input int j);
        return v[PRW*j +: PRW];
    endfunction

    function automatic logic exp_any();
        logic a = 1'b0;
        for (int j = 0; j < RW; j++) a = a | exp_vld[j];
        return a;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            spec_m[r] = 6'(r);
            arch_m[r] = 6'(r);
        end
        fl_q.delete();
        for (int p = 32; p < 64; p++) fl_q.push_back(6'(p));
        infl.delete();
        for (int j = 0; j < RW; j++) exp_vld[j] = 1'b0;
        stall_m = 0;
    endtask

    task automatic idle();
        d_vld = '0; d_wen = '0; c_vld = '0; c_wen = '0; sq = 1'b0; disp = 1'b1;
        for (int j = 0; j < RW; j++) begin
            d_rs1[j] = '0; d_rs2[j] = '0; d_rd[j] = '0;
        end
        for (int k = 0; k < CW; k++) begin
            c_ard[k] = '0; c_prd[k] = '0; c_old[k] = '0;
        end
    endtask

    task automatic drive();
        bus.i_squash_vld = sq;
        bus.i_dec_vld    = d_vld;
        bus.i_rd_wen     = d_wen;
        bus.i_disp_rdy   = disp;
        bus.i_cmt_vld    = c_vld;
        bus.i_cmt_wen    = c_wen;
        for (int j = 0; j < RW; j++) begin
            bus.i_rs1[5*j +: 5] = d_rs1[j];
            bus.i_rs2[5*j +: 5] = d_rs2[j];
            bus.i_rd[5*j +: 5]  = d_rd[j];
        end
        for (int k = 0; k < CW; k++) begin
            bus.i_cmt_ard[5*k +: 5]         = c_ard[k];
            bus.i_cmt_prd[PRW*k +: PRW]     = c_prd[k];
            bus.i_cmt_old_prd[PRW*k +: PRW] = c_old[k];
        end
    endtask

    task automatic set_lane(input int j, input logic [4:0] rdv, input logic [4:0] r1,
                            input logic [4:0] r2, input logic wen);
        d_vld[j] = 1'b1; d_wen[j] = wen; d_rd[j] = rdv; d_rs1[j] = r1; d_rs2[j] = r2;
    endtask

    task automatic cmt_front(input int k);
        rec_t r;
        r = infl.pop_front();
        c_vld[k] = 1'b1; c_wen[k] = 1'b1;
        c_ard[k] = r.ard; c_prd[k] = r.prd; c_old[k] = r.old;
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic run_cycle();
        logic rdy_m, any;
        drive();
        #1;
        any   = |d_vld;
        rdy_m = !sq && (fl_q.size() >= RW) && (!exp_any() || disp);
        chk("dec_rdy", 64'(bus.o_dec_rdy), 64'(rdy_m));
        if (any && !rdy_m && !sq) stall_m++;
        for (int k = 0; k < CW; k++) begin
            if (c_vld[k] && c_wen[k]) begin
                if (c_ard[k] != '0) arch_m[c_ard[k]] = c_prd[k];
                fl_q.push_back(c_old[k]);
            end
        end
        if (sq) begin
            for (int i = infl.size() - 1; i >= 0; i--) fl_q.push_front(infl[i].prd);
            infl.delete();
            for (int r = 0; r < 32; r++) spec_m[r] = arch_m[r];
            for (int j = 0; j < RW; j++) exp_vld[j] = 1'b0;
        end else if (rdy_m && any) begin
            for (int j = 0; j < RW; j++) begin
                exp_vld[j] = d_vld[j];
                if (d_vld[j]) begin
                    e_prs1[j] = spec_m[d_rs1[j]];
                    e_prs2[j] = spec_m[d_rs2[j]];
                    e_prd[j]  = '0;
                    e_old[j]  = '0;
                    if (d_wen[j] && d_rd[j] != '0) begin
                        e_old[j] = spec_m[d_rd[j]];
                        e_prd[j] = fl_q.pop_front();
                        spec_m[d_rd[j]] = e_prd[j];
                        infl.push_back('{ard: d_rd[j], prd: e_prd[j], old: e_old[j]});
                    end
                end
            end
        end else if (disp) begin
            for (int j = 0; j < RW; j++) exp_vld[j] = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int j = 0; j < RW; j++) begin
            chk($sformatf("ren_vld[%0d]", j), 64'(bus.o_ren_vld[j]), 64'(exp_vld[j]));
            if (exp_vld[j]) begin
                chk($sformatf("prs1[%0d]", j), 64'(lane6(bus.o_prs1, j)), 64'(e_prs1[j]));
                chk($sformatf("prs2[%0d]", j), 64'(lane6(bus.o_prs2, j)), 64'(e_prs2[j]));
                chk($sformatf("prd[%0d]", j), 64'(lane6(bus.o_prd, j)), 64'(e_prd[j]));
                chk($sformatf("old_prd[%0d]", j), 64'(lane6(bus.o_old_prd, j)), 64'(e_old[j]));
            end
        end
        chk("free_cnt", 64'(bus.o_free_cnt), 64'(fl_q.size()));
`ifdef RENAME_STALL_CNT_EN
        chk("stall_cnt", 64'(bus.o_stall_cnt), 64'(stall_m));
`endif
    endtask

    task automatic do_reset();
        idle();
        drive();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_ren_vld", 64'(bus.o_ren_vld), 64'(0));
        chk("rst_prd", 64'(bus.o_prd), 64'(0));
        chk("rst_old_prd", 64'(bus.o_old_prd), 64'(0));
        chk("rst_prs1", 64'(bus.o_prs1), 64'(0));
        chk("rst_free_cnt", 64'(bus.o_free_cnt), 64'(32));
        rst = 1'b1;
    endtask

    task automatic gen_rand(input int cmt_pct, input int sq_pct, input bit narrow);
        int  n;
        bit  stop;
        rec_t r;
        n = $urandom_range(0, RW);
        for (int j = 0; j < RW; j++) begin
            d_vld[j] = (j < n);
            d_wen[j] = ($urandom_range(0, 9) < 8);
            d_rs1[j] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            d_rs2[j] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            d_rd[j]  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
        end
        stop = 1'b0;
        for (int k = 0; k < CW; k++) begin
            c_vld[k] = 1'b0; c_wen[k] = 1'b0;
            c_ard[k] = 5'($urandom); c_prd[k] = 6'($urandom); c_old[k] = 6'($urandom);
            if (!stop && $urandom_range(0, 99) < cmt_pct) begin
                if (infl.size() > 0 && $urandom_range(0, 3) != 0) begin
                    r = infl.pop_front();
                    c_vld[k] = 1'b1; c_wen[k] = 1'b1;
                    c_ard[k] = r.ard; c_prd[k] = r.prd; c_old[k] = r.old;
                end else begin
                    c_vld[k] = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
        sq   = ($urandom_range(0, 99) < sq_pct);
        disp = ($urandom_range(0, 9) < 7);
    endtask

    initial begin
        rst = 1'b0;
        do_reset();

        // single lane, rd=x5 reading x5
        idle(); set_lane(0, 5'd5, 5'd5, 5'd0, 1'b1);
        run_cycle();
        chk("t1_prs1", 64'(lane6(bus.o_prs1, 0)), 64'(5));
        chk("t1_prd", 64'(lane6(bus.o_prd, 0)), 64'(32));
        chk("t1_old_prd", 64'(lane6(bus.o_old_prd, 0)), 64'(5));
        chk("t1_free", 64'(bus.o_free_cnt), 64'(31));

        // four lanes chained on x3, then a reader of x3 with an rd=x0 write
        do_reset();
        idle();
        for (int j = 0; j < RW; j++) set_lane(j, 5'd3, 5'd3, 5'd0, 1'b1);
        run_cycle();
        for (int j = 0; j < RW; j++) begin
            chk($sformatf("t2_prs1[%0d]", j), 64'(lane6(bus.o_prs1, j)), 64'(j == 0 ? 3 : 31 + j));
            chk($sformatf("t2_old[%0d]", j), 64'(lane6(bus.o_old_prd, j)), 64'(j == 0 ? 3 : 31 + j));
        end
        idle(); set_lane(0, 5'd0, 5'd3, 5'd0, 1'b1);
        run_cycle();
        chk("t3_prs1_x3", 64'(lane6(bus.o_prs1, 0)), 64'(35));
        chk("t3_prd_x0", 64'(lane6(bus.o_prd, 0)), 64'(0));
        chk("t3_free", 64'(bus.o_free_cnt), 64'(28));

        // drain the free list to 3, stall a full group, then free one preg by commit
        do_reset();
        for (int g = 0; g < 7; g++) begin
            idle();
            for (int j = 0; j < RW; j++) set_lane(j, 5'(4*g + j + 1), 5'd0, 5'd0, 1'b1);
            run_cycle();
        end
        idle(); set_lane(0, 5'd29, 5'd1, 5'd2, 1'b1);
        run_cycle();
        chk("t4_free3", 64'(bus.o_free_cnt), 64'(3));
        idle();
        for (int j = 0; j < RW; j++) set_lane(j, 5'(j + 1), 5'd7, 5'd8, 1'b1);
        run_cycle();
        chk("t4_blocked", 64'(bus.o_dec_rdy), 64'(0));
        cmt_front(0);
        run_cycle();
        chk("t4_free4", 64'(bus.o_free_cnt), 64'(4));
        c_vld = '0; c_wen = '0;
        drive();
        #1;
        chk("t4_rdy_rise", 64'(bus.o_dec_rdy), 64'(1));
        run_cycle();

        // commit x1 and squash in the same cycle
        do_reset();
        idle(); set_lane(0, 5'd1, 5'd0, 5'd0, 1'b1); set_lane(1, 5'd2, 5'd0, 5'd0, 1'b1);
        run_cycle();
        idle(); cmt_front(0); sq = 1'b1;
        run_cycle();
        chk("t5_vld_off", 64'(bus.o_ren_vld), 64'(0));
        idle(); set_lane(0, 5'd3, 5'd1, 5'd2, 1'b1);
        run_cycle();
        chk("t5_x1", 64'(lane6(bus.o_prs1, 0)), 64'(32));
        chk("t5_x2", 64'(lane6(bus.o_prs2, 0)), 64'(2));
        chk("t5_next_alloc", 64'(lane6(bus.o_prd, 0)), 64'(33));

        // dispatch back-pressure for three cycles
        do_reset();
        idle();
        for (int j = 0; j < RW; j++) set_lane(j, 5'(j + 4), 5'(j), 5'(j + 1), 1'b1);
        run_cycle();
        idle();
        for (int j = 0; j < RW; j++) set_lane(j, 5'(j + 10), 5'(j + 4), 5'd0, 1'b1);
        disp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            run_cycle();
            chk("t6_hold_rdy", 64'(bus.o_dec_rdy), 64'(0));
        end
        chk("t6_held_prd0", 64'(lane6(bus.o_prd, 0)), 64'(32));
        chk("t6_held_prs1_3", 64'(lane6(bus.o_prs1, 3)), 64'(3));
`ifdef RENAME_STALL_CNT_EN
        chk("t6_stall3", 64'(bus.o_stall_cnt), 64'(3));
`endif
        disp = 1'b1;
        run_cycle();

        // random traffic: a low-commit phase that starves the free list, then a busy phase
        do_reset();
        for (int c = 0; c < 800; c++) begin
            gen_rand(c < 400 ? 20 : 70, c < 400 ? 1 : 3, c[0]);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
        $finish;
    end
endmodule
